// File: rtl/bit_pkg.sv
// Shared types and width helpers for the sticky right-shift denormaliser.
package bit_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} denorm_state_t;

    // Shift-amount width able to hold BIT+1, the saturated shift count.
    function automatic int shw(input int bit_msb);
        return $clog2(bit_msb + 2);
    endfunction

    // Shifting by more than BIT+1 clears the vector, just like BIT+1 does.
    function automatic int sat_shamt(input int shamt, input int bit_msb);
        return (shamt > bit_msb) ? (bit_msb + 1) : shamt;
    endfunction

endpackage

// File: rtl/sticky_rshift_barrel.sv
// Single-cycle right shift with sticky OR of the discarded bits.
// Only instantiated when DENORM_BARREL_EN is defined.
module sticky_rshift_barrel
    import bit_pkg::*;
#(
    parameter int BIT = 16,
    localparam int SW = shw(BIT)
) (
    input  logic [BIT:0]  data,
    input  logic [SW-1:0] shamt,
    output logic [BIT:0]  data_o,
    output logic          sticky_o
);

    logic [BIT:0] mask;

    always_comb begin
        data_o = '0;
        mask   = '1;
        if (int'(shamt) <= BIT) begin
            data_o = data >> shamt;
            mask   = ~({(BIT+1){1'b1}} << shamt);
        end
        sticky_o = |(data & mask);
    end

endmodule

// File: rtl/sticky_rshift_denorm.sv
// Right-shifts a normalised value by the LOD count and reports a sticky bit.
// Define DENORM_BARREL_EN for a single-cycle barrel shift instead of the iterative one.
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready high unless rst
// SHIFT | one bit shifted out per cycle until count reaches zero
// DONE  | result held on out_data/out_sticky until out_ready
module sticky_rshift_denorm
    import bit_pkg::*;
#(
    parameter int BIT = 16,
    localparam int SW = shw(BIT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BIT:0]  in_data,
    input  logic [SW-1:0] in_shamt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BIT:0]  out_data,
    output logic          out_sticky,
    output logic          busy
);

    denorm_state_t state, state_n;
    logic [BIT:0]  data_q, data_n;
    logic          sticky_q, sticky_n;
    logic [SW-1:0] count_q, count_n;
    logic [SW-1:0] shamt_sat;

    assign shamt_sat = SW'(sat_shamt(int'(in_shamt), BIT));

`ifdef DENORM_BARREL_EN
    logic [BIT:0] barrel_data;
    logic         barrel_sticky;

    sticky_rshift_barrel #(.BIT(BIT)) u_barrel (
        .data     (in_data),
        .shamt    (shamt_sat),
        .data_o   (barrel_data),
        .sticky_o (barrel_sticky)
    );
`endif

    assign in_ready   = (state == IDLE) && !rst;
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign out_data   = data_q;
    assign out_sticky = sticky_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            data_q   <= '0;
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state    <= state_n;
            data_q   <= data_n;
            sticky_q <= sticky_n;
            count_q  <= count_n;
        end
    end

    always_comb begin
        state_n  = state;
        data_n   = data_q;
        sticky_n = sticky_q;
        count_n  = count_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
`ifdef DENORM_BARREL_EN
                    data_n   = barrel_data;
                    sticky_n = barrel_sticky;
                    count_n  = '0;
                    state_n  = DONE;
`else
                    data_n   = in_data;
                    sticky_n = 1'b0;
                    count_n  = shamt_sat;
                    state_n  = (shamt_sat == '0) ? DONE : SHIFT;
`endif
                end
            end
            SHIFT: begin
                // A zero count here can only come from corruption; bail out to DONE.
                if (count_q == '0) begin
                    state_n = DONE;
                end else begin
                    sticky_n = sticky_q | data_q[0];
                    data_n   = data_q >> 1;
                    count_n  = count_q - SW'(1);
                    if (count_q == SW'(1)) state_n = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sticky_rshift_denorm.sv
// Directed bench for sticky_rshift_denorm with an expected-result queue.
// Latency expectations switch to one cycle when DENORM_BARREL_EN is defined.
module tb_sticky_rshift_denorm;

    localparam int BIT = 16;
    localparam int SW  = 5;

    typedef struct {
        logic [BIT:0] data;
        logic         sticky;
        int           lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [BIT:0]  in_data;
    logic [SW-1:0] in_shamt;
    logic          out_valid;
    logic          out_ready;
    logic [BIT:0]  out_data;
    logic          out_sticky;
    logic          busy;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    sticky_rshift_denorm #(.BIT(BIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_shamt   (in_shamt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sticky (out_sticky),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [BIT:0] d, input int sh);
        exp_t e;
        logic [31:0] wide;
        logic [31:0] lost;
        wide = {15'd0, d};
        if (sh > BIT) begin
            e.data   = '0;
            e.sticky = |d;
        end else begin
            lost     = wide & ((32'd1 << sh) - 32'd1);
            e.data   = d >> sh;
            e.sticky = |lost;
        end
`ifdef DENORM_BARREL_EN
        e.lat = 1;
`else
        e.lat = ((sh > BIT) ? (BIT + 1) : sh) + 1;
`endif
        return e;
    endfunction

    // Drive one operation, wait for its result, optionally stall the consumer.
    task automatic run_op(input logic [BIT:0] d, input int sh, input int stall, input bit poke);
        exp_t e;
        int   lat;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = SW'(sh);
        sb.push_back(model(d, sh));
        @(posedge clk);
        @(negedge clk);
        in_valid = poke;
        in_data  = BIT'($urandom);
        in_shamt = SW'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("out_valid_timeout", 32'(out_valid), 32'd1);
        e = sb.pop_front();
        check("latency", 32'(lat), 32'(e.lat));
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_sticky", 32'(out_sticky), 32'(e.sticky));
        for (int i = 0; i < stall; i++) begin
            check("stall_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_data", 32'(out_data), 32'(e.data));
            check("stall_out_sticky", 32'(out_sticky), 32'(e.sticky));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_hs_out_valid", 32'(out_valid), 32'd0);
        check("post_hs_in_ready", 32'(in_ready), 32'd1);
        check("post_hs_hold_data", 32'(out_data), 32'(e.data));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sticky", 32'(out_sticky), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        run_op(17'h0B400, 4, 0, 1'b0);
        run_op(17'h0B407, 3, 0, 1'b1);
        run_op(17'h1FFFF, 0, 0, 1'b0);
        run_op(17'h00001, 20, 0, 1'b1);
        run_op(17'h12345, 7, 3, 1'b0);
        run_op(17'h10000, 16, 0, 1'b0);
        run_op(17'h1FFFF, 17, 1, 1'b0);
        run_op(17'h00000, 31, 0, 1'b0);

        // Abort an operation with reset two cycles after it is accepted.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 17'h1ABCD;
        in_shamt = SW'(10);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_data", 32'(out_data), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        run_op(17'h0F0F1, 5, 0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            run_op(BIT'($urandom), int'($urandom_range(0, 31)), k % 2, k[0]);
        end

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
